// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master among NREQ local requesters,
// sequencing each command through the master and returning done/err/rdata.
module apb_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_write,
  input  logic [32*NREQ-1:0]     req_addr,
  input  logic [32*NREQ-1:0]     req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic [31:0]            rdata,
  output logic                   transfer,
  output logic                   READ_WRITE_DATA,
  output logic [31:0]            ahb_write_add,
  output logic [31:0]            ahb_write_data,
  output logic [31:0]            ahb_read_add,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PREADY,
  input  logic [31:0]            ahb_read_data_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 8;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            transfer_q, transfer_d;
  logic            rw_q, rw_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     raddr_q, raddr_d;

  logic            pickValid;
  logic [IW-1:0]   pickIdx;
  int              cand;
  logic            busy;
  logic            apbAccess;
  logic            complete;
  logic            expire;
  logic [31:0]     selAddr;
  logic [31:0]     selWdata;

  // Search starts just after the last granted index so every requester gets a turn.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!pickValid && req[cand]) begin
        pickValid = 1'b1;
        pickIdx   = IW'(cand);
      end
    end
  end

  assign selAddr  = req_addr[32*int'(pickIdx) +: 32];
  assign selWdata = req_wdata[32*int'(pickIdx) +: 32];

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign apbAccess = PSEL & PENABLE;
  assign complete  = busy & apbAccess & PREADY;
  assign expire    = busy & ~complete & (cnt_q == CNT_LIMIT);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = '0;
    rdata_d    = rdata_q;
    transfer_d = transfer_q;
    rw_d       = rw_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    raddr_d    = raddr_q;

    case (state_q)
      ST_IDLE: begin
        if (pickValid) begin
          gnt_d      = NREQ'(1) << pickIdx;
          last_d     = pickIdx;
          rw_d       = req_write[pickIdx];
          transfer_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_ISSUE;
          if (req_write[pickIdx]) begin
            waddr_d = selAddr;
            wdata_d = selWdata;
          end else begin
            raddr_d = selAddr;
          end
        end
      end

      ST_ISSUE, ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Completion wins over a timeout landing on the same edge.
        if (complete) begin
          done_d     = gnt_q;
          gnt_d      = '0;
          transfer_d = 1'b0;
          state_d    = ST_IDLE;
          if (!rw_q) begin
            rdata_d = ahb_read_data_out;
          end
        end else if (expire) begin
          err_d      = gnt_q;
          gnt_d      = '0;
          transfer_d = 1'b0;
          state_d    = ST_IDLE;
        end else if ((state_q == ST_ISSUE) && apbAccess) begin
          transfer_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end

      default: begin
        gnt_d      = '0;
        transfer_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      last_q     <= IW'(NREQ - 1);
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      transfer_q <= 1'b0;
      rw_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      transfer_q <= transfer_d;
      rw_q       <= rw_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      raddr_q    <= raddr_d;
    end
  end

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign transfer        = transfer_q;
  assign READ_WRITE_DATA = rw_q;
  assign ahb_write_add   = waddr_q;
  assign ahb_write_data  = wdata_q;
  assign ahb_read_add    = raddr_q;

  // Handshake outputs to requesters must never name more than one requester.
  a_gnt_onehot : assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(gnt_q));
  a_done_onehot : assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(done_q));
  a_err_onehot : assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(err_q));
  a_done_err_excl : assert property (@(posedge PCLK) disable iff (PRESET) !((|done_q) && (|err_q)));

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios then randomized
// transactions, all checked against a round-robin reference model.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            PCLK;
  logic            PRESET;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [32*N-1:0] req_addr;
  logic [32*N-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [N-1:0]    err;
  logic [31:0]     rdata;
  logic            transfer;
  logic            READ_WRITE_DATA;
  logic [31:0]     ahb_write_add;
  logic [31:0]     ahb_write_data;
  logic [31:0]     ahb_read_add;
  logic            PSEL;
  logic            PENABLE;
  logic            PREADY;
  logic [31:0]     ahb_read_data_out;

  apb_master_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .transfer(transfer),
    .READ_WRITE_DATA(READ_WRITE_DATA), .ahb_write_add(ahb_write_add),
    .ahb_write_data(ahb_write_data), .ahb_read_add(ahb_read_add),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY),
    .ahb_read_data_out(ahb_read_data_out)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: requester fields plus what each output should hold.
  logic [31:0] mAddr [N];
  logic [31:0] mData [N];
  logic [N-1:0] mWrite;
  int          lastIdx;
  int          curIdx;
  logic        expRw;
  logic [31:0] expRdata, expWAddr, expWData, expRAddr;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oneHot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int modelPick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(lastIdx + k) % N]) return (lastIdx + k) % N;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] r);
    req       = r;
    req_write = mWrite;
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32]  = mAddr[i];
      req_wdata[32*i +: 32] = mData[i];
    end
  endtask

  task automatic modelReset();
    lastIdx  = N - 1;
    expRw    = 1'b0;
    expRdata = '0;
    expWAddr = '0;
    expWData = '0;
    expRAddr = '0;
  endtask

  // Drive a request vector across one edge and check the resulting grant.
  task automatic grantStep(input logic [N-1:0] r);
    applyStimulus(r);
    curIdx = modelPick(r);
    tick();
    lastIdx = curIdx;
    expRw   = mWrite[curIdx];
    if (expRw) begin
      expWAddr = mAddr[curIdx];
      expWData = mData[curIdx];
    end else begin
      expRAddr = mAddr[curIdx];
    end
    checkOutput("grant", gnt, oneHot(curIdx));
    checkOutput("grantXfer", transfer, 1);
    checkOutput("grantRw", READ_WRITE_DATA, expRw);
    checkOutput("grantWAddr", ahb_write_add, expWAddr);
    checkOutput("grantWData", ahb_write_data, expWData);
    checkOutput("grantRAddr", ahb_read_add, expRAddr);
    checkOutput("grantDoneLow", done, 0);
    checkOutput("grantErrLow", err, 0);
  endtask

  // Bench-side APB master: setup, access, then PREADY after 'waits' extra cycles.
  task automatic apbComplete(input int waits, input logic [31:0] readVal);
    PSEL = 1'b1; PENABLE = 1'b0; PREADY = 1'b0;
    tick();
    checkOutput("setupXfer", transfer, 1);
    checkOutput("setupGnt", gnt, oneHot(curIdx));
    PENABLE = 1'b1; PREADY = (waits == 0); ahb_read_data_out = readVal;
    tick();
    if (waits > 0) begin
      checkOutput("accessXfer", transfer, 0);
      checkOutput("accessDone", done, 0);
      checkOutput("accessGnt", gnt, oneHot(curIdx));
      for (int i = 1; i <= waits; i++) begin
        PREADY = (i == waits);
        tick();
        if (i < waits) checkOutput("waitDone", done, 0);
      end
    end
    if (!expRw) expRdata = readVal;
    checkOutput("done", done, oneHot(curIdx));
    checkOutput("doneGnt", gnt, 0);
    checkOutput("doneErr", err, 0);
    checkOutput("doneXfer", transfer, 0);
    checkOutput("doneRdata", rdata, expRdata);
    PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0;
  endtask

  initial begin
    int prev;
    int waits;
    logic [N-1:0] r;

    for (int i = 0; i < N; i++) begin
      mAddr[i] = '0;
      mData[i] = '0;
    end
    mWrite = '0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0;
    ahb_read_data_out = '0;
    applyStimulus('0);
    modelReset();
    tick();
    tick();
    checkOutput("rstGnt", gnt, 0);
    checkOutput("rstXfer", transfer, 0);
    checkOutput("rstRdata", rdata, 0);
    checkOutput("rstRw", READ_WRITE_DATA, 0);
    PRESET = 1'b0;

    // Single write from requester 0.
    mWrite[0] = 1'b1; mAddr[0] = 32'h04; mData[0] = 32'h55;
    grantStep(4'b0001);
    checkOutput("wrGntConst", gnt, 4'b0001);
    checkOutput("wrAddrConst", ahb_write_add, 32'h04);
    checkOutput("wrDataConst", ahb_write_data, 32'h55);
    applyStimulus('0);
    apbComplete(1, 32'hDEAD_BEEF);

    // Read from requester 2; rdata must hold after the completion pulse.
    mWrite[2] = 1'b0; mAddr[2] = 32'h01;
    grantStep(4'b0100);
    checkOutput("rdAddrConst", ahb_read_add, 32'h01);
    applyStimulus('0);
    apbComplete(1, 32'h65);
    checkOutput("rdDataConst", rdata, 32'h65);
    tick();
    checkOutput("rdHold", rdata, 32'h65);
    checkOutput("doneOneCycle", done, 0);

    // Zero-wait completion straight out of ISSUE.
    mWrite[1] = 1'b1; mAddr[1] = 32'h10; mData[1] = 32'hAA;
    grantStep(4'b0010);
    applyStimulus('0);
    apbComplete(0, 32'h0);

    // Timeout: PREADY never rises.
    mWrite[1] = 1'b0; mAddr[1] = 32'h20;
    grantStep(4'b0010);
    applyStimulus('0);
    PSEL = 1'b1; PENABLE = 1'b0; PREADY = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      PENABLE = (k >= 2);
      tick();
      if (k < TO) begin
        checkOutput("toErrEarly", err, 0);
        checkOutput("toDoneEarly", done, 0);
      end
    end
    checkOutput("toErr", err, 4'b0010);
    checkOutput("toDone", done, 0);
    checkOutput("toGnt", gnt, 0);
    checkOutput("toXfer", transfer, 0);
    checkOutput("toRdata", rdata, expRdata);
    PSEL = 1'b0; PENABLE = 1'b0;
    mWrite[3] = 1'b0; mAddr[3] = 32'h300;
    grantStep(4'b1000);
    applyStimulus('0);
    apbComplete(2, 32'h1234_5678);

    // Reset while waiting on PREADY.
    mWrite[2] = 1'b1; mAddr[2] = 32'h44; mData[2] = 32'h99;
    grantStep(4'b0100);
    applyStimulus('0);
    PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PRESET = 1'b1;
    applyStimulus(4'b1111);
    tick();
    modelReset();
    checkOutput("midRstGnt", gnt, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstErr", err, 0);
    checkOutput("midRstXfer", transfer, 0);
    checkOutput("midRstRdata", rdata, 0);
    checkOutput("midRstWAddr", ahb_write_add, 0);
    checkOutput("midRstRw", READ_WRITE_DATA, 0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;

    // Round-robin with all requests held: expect 0,1,2,3,0.
    for (int i = 0; i < N; i++) begin
      mWrite[i] = i[0];
      mAddr[i]  = 32'h1000 + i;
      mData[i]  = 32'h2000 + i;
    end
    grantStep(4'b1111);
    checkOutput("rrOrder", gnt, 4'b0001);
    for (int n = 1; n <= N; n++) begin
      apbComplete(1, $urandom);
      prev = curIdx;
      grantStep(4'b1111);
      checkOutput("rrOrder", gnt, oneHot(n % N));
      checkOutput("rrNoRepeat", gnt & oneHot(prev), 0);
    end
    applyStimulus('0);
    apbComplete(0, $urandom);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      tick();
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        mWrite[i] = 1'($urandom_range(0, 1));
        mAddr[i]  = $urandom;
        mData[i]  = $urandom;
      end
      waits = $urandom_range(0, 4);
      grantStep(r);
      applyStimulus('0);
      apbComplete(waits, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin arbiter and sequencer that shares the single APB master between NREQ local requesters. It picks one pending request, drives the master's environment-side command inputs (`transfer`, `READ_WRITE_DATA`, write/read address and write data), and watches the master's APB outputs plus `PREADY` for completion. It then returns read data and a completion or error pulse to the granted requester. It sits directly in front of the APB master, on the environment side.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: maximum cycles from grant to completion before abort, 2..255.
- `PCLK`  in  1  sole clock; all state updates on the rising edge.
- `PRESET`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  level request per requester.
- `req_write`  in  NREQ  1 = write, 0 = read, per requester.
- `req_addr`  in  32*NREQ  flattened addresses; requester i uses bits [32i+31:32i].
- `req_wdata`  in  32*NREQ  flattened write data, same packing.
- `gnt`  out  NREQ  one-hot grant, high for the whole transaction.
- `done`  out  NREQ  one-cycle completion pulse to the granted requester.
- `err`  out  NREQ  one-cycle timeout-abort pulse to the granted requester.
- `rdata`  out  32  read data captured at read completion; holds until the next read completion.
- `transfer`  out  1  to master: start a transfer.
- `READ_WRITE_DATA`  out  1  to master: 1 = write, 0 = read.
- `ahb_write_add`, `ahb_write_data`, `ahb_read_add`  out  32 each  to master.
- `PSEL`, `PENABLE`, `PREADY`  in  1 each  observed APB bus signals.
- `ahb_read_data_out`  in  32  read data returned by the master.

## Operation
- States: IDLE, ISSUE, WAIT.
- All outputs are registered. Reset value of every output is 0. Reset also sets the state to IDLE, the pointer `last` to NREQ-1 and the timeout counter to 0.
- **IDLE:** if any `req` bit is high, select the first set bit searching `last+1`, `last+2`, … modulo NREQ. At that edge:
  - set `gnt[i]`; update `last` to i;
  - load `READ_WRITE_DATA` from `req_write[i]`;
  - for a write, load `ahb_write_add` and `ahb_write_data`; for a read, load `ahb_read_add`; unused address/data outputs hold their previous value;
  - set `transfer` to 1; clear the counter; go to ISSUE.
- If no request is pending, stay in IDLE.
- **ISSUE:** `transfer` is held at 1.
  - `PSEL & PENABLE` sampled high → `transfer` goes to 0 and the state moves to WAIT.
  - If `PREADY` is also high at that edge, complete immediately (see completion).
- **WAIT:** `transfer` = 0. `PSEL & PENABLE & PREADY` sampled high → completion.
- **Completion edge:**
  - pulse `done[i]`; clear `gnt`;
  - if the transaction was a read, capture `ahb_read_data_out` into `rdata`;
  - return to IDLE.
- **Timeout:** the counter increments every cycle in ISSUE or WAIT. When it reaches TIMEOUT-1 without completion:
  - pulse `err[i]` instead of `done[i]`; clear `transfer` and `gnt`; return to IDLE;
  - `rdata` is unchanged and `last` keeps the aborted index.
- Completion takes priority over timeout when both occur at the same edge.
- Requester contract: `req_*` fields are stable while `req[i]` is high and un-granted. They are sampled only at the grant edge. `req` is level-sensitive: a requester still holding `req` after `done` is re-arbitrated normally.
- `PRESET` mid-transaction returns to IDLE immediately with no `done` or `err` pulse.

## Timing
- Request-to-grant: `req` high in cycle c gives `gnt` and `transfer` high in cycle c+1, when in IDLE.
- `transfer` stays high until the first edge where `PSEL & PENABLE` is sampled high.
- `done`/`err` is high for exactly one cycle, the cycle after the completion or timeout edge. `gnt` falls in that same cycle.
- Minimum one IDLE cycle between transactions; back-to-back grants are spaced 1 cycle + the APB transfer time.
- Only one `gnt`, `done` or `err` bit is ever high at once.

## Test plan
- **Single write.** req0, write, addr 0x04, data 0x55; bench master model raises PREADY in the 2nd access cycle. Expect: `gnt`=0001; `ahb_write_add`=0x04; `ahb_write_data`=0x55; `READ_WRITE_DATA`=1; `transfer` drops on the PSEL&PENABLE edge; `done[0]` pulses once.
- **Read.** req2, read, addr 0x01; master returns 0x65. Expect: `ahb_read_add`=0x01; `rdata`=0x65 in the `done[2]` cycle; `rdata` holds afterwards.
- **Round-robin.** All four `req` held high continuously. Expect grant order 0,1,2,3,0 with `done` after each, and no requester granted twice in a row.
- **Timeout.** TIMEOUT=16, req1, PREADY held at 0. Expect `err[1]` pulse 16 cycles after grant, `done` never asserted, `transfer`=0, return to IDLE; a following req3 is granted normally.
- **Reset mid-transaction.** `PRESET` high during WAIT. Expect all outputs 0 next cycle, no `done`/`err` pulse; after reset, with all `req` high, requester 0 is granted first.
- **Zero-wait completion.** PREADY already high when PENABLE rises. Expect completion directly from ISSUE, with `done` one cycle later.
